conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Streaming front end for the 3x3 convolution engine. It accepts a raster-order pixel stream (one 8-bit pixel per cycle) and a serial 9-byte kernel. It buffers two image lines and emits each complete 3x3 window on `In_IFM_1..9` with `in_valid`. It presents the kernel on `In_Weight_1..9` with a one-cycle `weight_valid`, driving the convolution engine's input interface directly.

## Interface
- `IMG_W`, 8: pixels per line (>= 3)
- `IMG_H`, 8: lines per frame (>= 3)
- `DATA_W`, 8: pixel/weight width
- `clk` input 1: single clock, all logic rising-edge
- `rst_n` input 1: reset, synchronous and active-high (asserted = 1), as decided for this block
- `pix_valid` input 1: `pix_in` valid this cycle
- `pix_in` input DATA_W: pixel, raster order
- `w_valid` input 1: `w_in` valid this cycle
- `w_in` input DATA_W: kernel byte, order W1..W9 (row-major)
- `in_valid` output 1: window valid on `In_IFM_*`
- `In_IFM_1..In_IFM_9` output DATA_W each: window, row-major, 1 = top-left, 9 = bottom-right
- `weight_valid` output 1: one-cycle pulse, kernel valid on `In_Weight_*`
- `In_Weight_1..In_Weight_9` output DATA_W each: kernel
- `frame_done` output 1: one-cycle pulse with the last window of a frame

## Operation
- **States:**
  - `S_WLOAD`: collect kernel bytes.
  - `S_STREAM`: accept pixels.
  - Reset enters `S_WLOAD`.
- **S_WLOAD:**
  - Each `w_valid` cycle writes `w_in` to weight register `widx` (0..8) and increments `widx`.
  - On the 9th byte, go to `S_STREAM` and pulse `weight_valid` the next cycle.
  - `pix_valid` is ignored in this state.
- **S_STREAM:**
  - Each `pix_valid` cycle shifts `pix_in` into the 3x3 window and the line buffers, and advances `col`/`row`.
  - `col` wraps `IMG_W-1` -> 0 and increments `row`.
  - `row = IMG_H-1` with `col` wrapping ends the frame: `row` and `col` return to 0 and the state stays `S_STREAM`.
- **Window emission:**
  - A window is emitted for an accepted pixel at (`row`, `col`) with `row >= 2` and `col >= 2`.
  - The window covers rows `row-2..row` and columns `col-2..col`.
  - Windows per frame = (IMG_H-2)*(IMG_W-2).
  - No window is emitted for `col < 2`. The window contents must never straddle a line wrap.
- **Kernel reload:**
  - `w_valid` in `S_STREAM` while `row = col = 0` (frame boundary, no pixel accepted this cycle) returns to `S_WLOAD` and loads that byte as W1.
  - `w_valid` mid-frame is ignored.
  - If `pix_valid` and `w_valid` are both high at a frame boundary, `w_valid` wins and the pixel is dropped.
- **Output hold (low-power):**
  - `In_IFM_*` update only when `in_valid` is asserted, and hold otherwise.
  - `In_Weight_*` update only on the `weight_valid` cycle.
- **Reset values:**
  - Every output is 0 (`in_valid`, `weight_valid`, `frame_done`, all `In_IFM_*`, all `In_Weight_*`).
  - Counters, `widx` and the line buffers are also cleared.
- **Reset mid-operation:**
  - Discards the partial frame and partial kernel.
  - No `in_valid` pulse occurs in the cycle after reset is asserted.
- **No back-pressure:** the engine accepts every asserted window. Gaps in `pix_valid` simply stall the stream and hold all state.

## Timing
- **Window latency:** 1 cycle. `in_valid` and `In_IFM_*` are registered and appear the cycle after the completing pixel is accepted.
- **Kernel latency:** `weight_valid` appears the cycle after the 9th `w_valid` byte. `In_Weight_*` become valid in that same cycle and stay stable until the next reload completes.
- **`frame_done`:** coincides with `in_valid` for window (IMG_H-3, IMG_W-3).
- **Back-to-back frames:** the first pixel of frame N+1 may be accepted the cycle after the last pixel of frame N.
- **Window-to-kernel ordering:** `weight_valid` always precedes the first `in_valid` that uses that kernel by at least 1 cycle.

## Structure
- **Package `conv_feed_pkg`:**
  - `KSIZE = 3`
  - `KTAPS = 9`
  - default `DATA_W`
  - state enum `{S_WLOAD, S_STREAM}`
- **Sub-module `line_buffer`:** parameterised depth IMG_W, DATA_W wide, shift enable. Two instances are chained (row-1 and row-2 taps).
- **Top level contains:** the 3x3 window registers, the `col`/`row` counters, the FSM, the weight registers, and the output registers.

## Test plan
- **Kernel load:** reset, then `w_in` = 1..9 on consecutive cycles -> `weight_valid` = 1 for exactly one cycle after the 9th byte, `In_Weight_1..9` = 1..9, outputs 0 before that.
- **Basic 4x4 frame** (IMG_W = IMG_H = 4), pixels 0..15 back-to-back:
  - exactly 4 `in_valid` pulses
  - first pulse the cycle after pixel 10, with IFM = 0,1,2,4,5,6,8,9,10
  - last pulse with IFM = 5,6,7,9,10,11,13,14,15 and `frame_done` = 1
- **Stalls:** same frame with `pix_valid` toggling 1,0,0,1,... -> identical window contents. Each `in_valid` is exactly 1 cycle after its completing pixel, and `In_IFM_*` hold between pulses.
- **Kernel reload timing:** `w_valid` asserted mid-frame is ignored and the kernel is unchanged. Kernel 9..1 loaded at the frame boundary -> `In_Weight_1..9` = 9..1 before the next frame's first window.
- **Reset mid-frame:** `rst_n` = 1 after pixel 6 -> all outputs 0 next cycle. A new kernel plus full frame afterwards -> the same 4 windows as the basic 4x4 test.
- **Back-to-back frames:** frame 0..15 then 100..115 with no gap -> 8 windows. The 5th window is 100,101,102,104,105,106,108,109,110, and no window mixes the two frames.

Source files
------------

// File: rtl/conv_window_feeder_pkg.sv
// ============================================================================
//  Module   : conv_feed_pkg
//  Purpose  : Shared constants and state type for the 3x3 convolution feeder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_feed_pkg;
    localparam int KSIZE      = 3;
    localparam int KTAPS      = 9;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [0:0] {
        S_WLOAD  = 1'b0,
        S_STREAM = 1'b1
    } state_t;
endpackage

`default_nettype wire

// File: rtl/conv_window_feeder_if.sv
// ============================================================================
//  Module   : conv_window_feeder_if
//  Purpose  : Pixel/kernel input stream and convolution-engine output bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface conv_window_feeder_if
    import conv_feed_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_in;
    logic              w_valid;
    logic [DATA_W-1:0] w_in;
    logic              in_valid;
    logic [DATA_W-1:0] In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5,
                       In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9;
    logic              weight_valid;
    logic [DATA_W-1:0] In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4, In_Weight_5,
                       In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9;
    logic              frame_done;

    // master: stream source / engine side; slave: the feeder itself
    modport master (
        output pix_valid, pix_in, w_valid, w_in,
        input  in_valid, In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5,
               In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9,
        input  weight_valid, In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
               In_Weight_5, In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9,
        input  frame_done
    );

    modport slave (
        input  pix_valid, pix_in, w_valid, w_in,
        output in_valid, In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5,
               In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9,
        output weight_valid, In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
               In_Weight_5, In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9,
        output frame_done
    );
endinterface

`default_nettype wire

// File: rtl/conv_window_feeder_line_buffer.sv
// ============================================================================
//  Module   : line_buffer
//  Purpose  : One image line of delay; o_tap is the pixel pushed DEPTH shifts ago.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module line_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_en,
    input  wire logic [DATA_W-1:0] i_data,
    output logic      [DATA_W-1:0] o_tap
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_tap = r_mem[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/conv_window_feeder.sv
// ============================================================================
//  Module   : conv_window_feeder
//  Purpose  : Raster pixel stream to 3x3 windows plus 9-tap kernel presenter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_window_feeder
    import conv_feed_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    conv_window_feeder_if.slave bus
);
    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

    state_t            r_state, w_state_next;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [3:0]        r_widx;
    logic [DATA_W-1:0] r_wstage [KTAPS-1];
    logic [DATA_W-1:0] r_wout   [KTAPS];
    logic [DATA_W-1:0] r_win    [KSIZE][KSIZE-1];
    logic [DATA_W-1:0] r_ifm    [KTAPS];
    logic              r_wvalid, r_ivalid, r_fdone;

    logic [DATA_W-1:0] w_tap1, w_tap2;
    logic [DATA_W-1:0] w_newcol [KSIZE];
    logic w_reload, w_accept, w_emit, w_kernel_done, w_frame_end;

    assign w_kernel_done = (r_state == S_WLOAD) && bus.w_valid && (r_widx == 4'd8);
    assign w_reload      = (r_state == S_STREAM) && bus.w_valid &&
                           (r_row == '0) && (r_col == '0);
    assign w_accept      = (r_state == S_STREAM) && bus.pix_valid && !w_reload;
    assign w_emit        = w_accept && (r_row >= c_ROW_W'(2)) && (r_col >= c_COL_W'(2));
    assign w_frame_end   = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_row1 (
        .clk(clk), .rst_n(rst_n), .i_en(w_accept), .i_data(bus.pix_in), .o_tap(w_tap1)
    );
    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_row2 (
        .clk(clk), .rst_n(rst_n), .i_en(w_accept), .i_data(w_tap1), .o_tap(w_tap2)
    );

    // Newest column of the window: rows row-2, row-1, row at the current col
    assign w_newcol[0] = w_tap2;
    assign w_newcol[1] = w_tap1;
    assign w_newcol[2] = bus.pix_in;

    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_WLOAD;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WLOAD:  if (w_kernel_done) w_state_next = S_STREAM;
            S_STREAM: if (w_reload)      w_state_next = S_WLOAD;
            default:  w_state_next = S_WLOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_widx   <= '0;
            r_wvalid <= 1'b0;
            r_ivalid <= 1'b0;
            r_fdone  <= 1'b0;
            for (int i = 0; i < KTAPS - 1; i++) r_wstage[i] <= '0;
            for (int i = 0; i < KTAPS; i++) begin
                r_wout[i] <= '0;
                r_ifm[i]  <= '0;
            end
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) r_win[r][c] <= '0;
            end
        end else begin
            r_wvalid <= w_kernel_done;
            r_ivalid <= w_emit;
            r_fdone  <= w_emit && w_frame_end;

            if (r_state == S_WLOAD && bus.w_valid) begin
                if (w_kernel_done) begin
                    r_widx <= '0;
                end else begin
                    r_wstage[r_widx[2:0]] <= bus.w_in;
                    r_widx                <= r_widx + 4'd1;
                end
            end else if (w_reload) begin
                r_wstage[0] <= bus.w_in;
                r_widx      <= 4'd1;
            end

            // Kernel outputs move only on the completing byte, i.e. with weight_valid
            if (w_kernel_done) begin
                for (int i = 0; i < KTAPS - 1; i++) r_wout[i] <= r_wstage[i];
                r_wout[KTAPS-1] <= bus.w_in;
            end

            if (w_accept) begin
                for (int r = 0; r < KSIZE; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= w_newcol[r];
                end
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_emit) begin
                for (int r = 0; r < KSIZE; r++) begin
                    r_ifm[r*KSIZE]     <= r_win[r][0];
                    r_ifm[r*KSIZE + 1] <= r_win[r][1];
                    r_ifm[r*KSIZE + 2] <= w_newcol[r];
                end
            end
        end
    end

    assign bus.in_valid     = r_ivalid;
    assign bus.frame_done   = r_fdone;
    assign bus.weight_valid = r_wvalid;
    assign bus.In_IFM_1 = r_ifm[0];
    assign bus.In_IFM_2 = r_ifm[1];
    assign bus.In_IFM_3 = r_ifm[2];
    assign bus.In_IFM_4 = r_ifm[3];
    assign bus.In_IFM_5 = r_ifm[4];
    assign bus.In_IFM_6 = r_ifm[5];
    assign bus.In_IFM_7 = r_ifm[6];
    assign bus.In_IFM_8 = r_ifm[7];
    assign bus.In_IFM_9 = r_ifm[8];
    assign bus.In_Weight_1 = r_wout[0];
    assign bus.In_Weight_2 = r_wout[1];
    assign bus.In_Weight_3 = r_wout[2];
    assign bus.In_Weight_4 = r_wout[3];
    assign bus.In_Weight_5 = r_wout[4];
    assign bus.In_Weight_6 = r_wout[5];
    assign bus.In_Weight_7 = r_wout[6];
    assign bus.In_Weight_8 = r_wout[7];
    assign bus.In_Weight_9 = r_wout[8];
endmodule

`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
// ============================================================================
//  Module   : tb_conv_window_feeder
//  Purpose  : Self-checking bench for conv_window_feeder on a 4x4 image.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_window_feeder;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    conv_window_feeder_if #(.DATA_W(DW)) bus ();

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: image of the current frame, kernel being collected
    bit          m_loading;
    int          m_wcnt;
    int          m_pos;
    logic [7:0]  m_kbuf [9];
    logic [7:0]  m_img  [W*H];
    logic        exp_iv, exp_fd, exp_wv;
    logic [71:0] exp_ifm, exp_wt;

    logic [71:0] got_win [$];
    logic        got_fd  [$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] dut_ifm();
        return {bus.In_IFM_1, bus.In_IFM_2, bus.In_IFM_3, bus.In_IFM_4, bus.In_IFM_5,
                bus.In_IFM_6, bus.In_IFM_7, bus.In_IFM_8, bus.In_IFM_9};
    endfunction

    function automatic logic [71:0] dut_wt();
        return {bus.In_Weight_1, bus.In_Weight_2, bus.In_Weight_3, bus.In_Weight_4,
                bus.In_Weight_5, bus.In_Weight_6, bus.In_Weight_7, bus.In_Weight_8,
                bus.In_Weight_9};
    endfunction

    task automatic model(input bit rst, input bit pv, input logic [7:0] p,
                         input bit wv, input logic [7:0] w);
        exp_iv = 1'b0;
        exp_fd = 1'b0;
        exp_wv = 1'b0;
        if (rst) begin
            m_loading = 1'b1;
            m_wcnt    = 0;
            m_pos     = 0;
            exp_ifm   = '0;
            exp_wt    = '0;
            return;
        end
        if (m_loading) begin
            if (wv) begin
                m_kbuf[m_wcnt] = w;
                m_wcnt++;
                if (m_wcnt == 9) begin
                    m_loading = 1'b0;
                    m_wcnt    = 0;
                    exp_wv    = 1'b1;
                    for (int k = 0; k < 9; k++) exp_wt[71-8*k -: 8] = m_kbuf[k];
                end
            end
        end else if (wv && m_pos == 0) begin
            m_loading = 1'b1;
            m_kbuf[0] = w;
            m_wcnt    = 1;
        end else if (pv) begin
            int r, c;
            r = m_pos / W;
            c = m_pos % W;
            m_img[m_pos] = p;
            if (r >= 2 && c >= 2) begin
                exp_iv = 1'b1;
                exp_fd = (m_pos == W*H - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_ifm[71-8*(3*i+j) -: 8] = m_img[(r-2+i)*W + (c-2+j)];
            end
            m_pos = (m_pos + 1) % (W*H);
        end
    endtask

    task automatic step(input bit rst, input bit pv, input logic [7:0] p,
                        input bit wv, input logic [7:0] w);
        rst_n         = rst;
        bus.pix_valid = pv;
        bus.pix_in    = p;
        bus.w_valid   = wv;
        bus.w_in      = w;
        @(posedge clk);
        model(rst, pv, p, wv, w);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic load_kernel(input logic [71:0] k);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1, k[71-8*i -: 8]);
    endtask

    task automatic send_frame(input int base, input bit stall);
        for (int i = 0; i < W*H; i++) begin
            step(1'b0, 1'b1, 8'(base + i), 1'b0, 8'h00);
            if (stall) idle(2);
        end
    endtask

    task automatic check_basic_windows(input string tag);
        chk({tag, "_count"}, 72'(got_win.size()), 72'd4);
        chk({tag, "_first"}, got_win[0], 72'h00_01_02_04_05_06_08_09_0A);
        chk({tag, "_first_fd"}, 72'(got_fd[0]), 72'd0);
        chk({tag, "_last"}, got_win[3], 72'h05_06_07_09_0A_0B_0D_0E_0F);
        chk({tag, "_last_fd"}, 72'(got_fd[3]), 72'd1);
    endtask

    // Per-cycle comparison against the model, plus capture of emitted windows
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_valid", 72'(bus.in_valid), 72'(exp_iv));
            chk("frame_done", 72'(bus.frame_done), 72'(exp_fd));
            chk("weight_valid", 72'(bus.weight_valid), 72'(exp_wv));
            chk("In_IFM", dut_ifm(), exp_ifm);
            chk("In_Weight", dut_wt(), exp_wt);
            if (bus.in_valid === 1'b1) begin
                got_win.push_back(dut_ifm());
                got_fd.push_back(bus.frame_done);
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk_en = 1'b1;
        chk("reset_ifm", dut_ifm(), 72'h0);
        chk("reset_wt", dut_wt(), 72'h0);
        chk("reset_flags", 72'({bus.in_valid, bus.weight_valid, bus.frame_done}), 72'h0);

        // Kernel load 1..9
        load_kernel(72'h01_02_03_04_05_06_07_08_09);
        chk("kload_wv", 72'(bus.weight_valid), 72'd1);
        chk("kload_wt", dut_wt(), 72'h01_02_03_04_05_06_07_08_09);
        idle(1);
        chk("kload_wv_pulse", 72'(bus.weight_valid), 72'd0);

        // Basic frame, back-to-back pixels
        got_win.delete(); got_fd.delete();
        send_frame(0, 1'b0);
        idle(2);
        check_basic_windows("basic");

        // Same frame with stalls
        got_win.delete(); got_fd.delete();
        send_frame(0, 1'b1);
        idle(2);
        check_basic_windows("stall");

        // Mid-frame w_valid ignored, then reload 9..1 at the boundary with a colliding pixel
        for (int i = 0; i < W*H; i++) begin
            if (i == 5) step(1'b0, 1'b1, 8'(i), 1'b1, 8'h55);
            else        step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        end
        idle(1);
        chk("midframe_wt", dut_wt(), 72'h01_02_03_04_05_06_07_08_09);
        step(1'b0, 1'b1, 8'hEE, 1'b1, 8'h09);
        for (int i = 1; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(9 - i));
        chk("reload_wv", 72'(bus.weight_valid), 72'd1);
        chk("reload_wt", dut_wt(), 72'h09_08_07_06_05_04_03_02_01);
        got_win.delete(); got_fd.delete();
        send_frame(0, 1'b0);
        idle(2);
        check_basic_windows("reload");

        // Reset mid-frame
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h07, 1'b0, 8'h00);
        chk("midrst_ifm", dut_ifm(), 72'h0);
        chk("midrst_wt", dut_wt(), 72'h0);
        chk("midrst_flags", 72'({bus.in_valid, bus.weight_valid, bus.frame_done}), 72'h0);
        load_kernel(72'h01_02_03_04_05_06_07_08_09);
        got_win.delete(); got_fd.delete();
        send_frame(0, 1'b0);
        idle(2);
        check_basic_windows("postrst");

        // Back-to-back frames
        got_win.delete(); got_fd.delete();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        idle(2);
        chk("b2b_count", 72'(got_win.size()), 72'd8);
        chk("b2b_fifth", got_win[4], 72'h64_65_66_68_69_6A_6C_6D_6E);
        chk("b2b_eighth", got_win[7], 72'h69_6A_6B_6D_6E_6F_71_72_73);
        chk("b2b_fourth_fd", 72'(got_fd[3]), 72'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
